rle_run_expander: RTL
=====================

Name: rle_run_expander

Overview:
- Write-side stage of the RLE decompression path, running in the wclk domain.
- Consumes an encoded byte stream of (count, value) token pairs and expands each run into repeated bytes.
- Pushes the expanded bytes into the downstream byte FIFO using the FIFO's wr / fifo_full handshake.
- Emits one byte per wclk cycle while the FIFO has room, and signals the end of each encoded frame.

Parameters:
- ZERO_IS_MAX, default 0. 0: a count byte of 0 is a zero-length run (no output). 1: a count byte of 0 means a run of 256.
- STAT_W, default 16. Width of the emitted-byte statistics counter.

Ports:
- wclk  input  1  write-domain clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  encoded byte present on in_data.
- in_data  input  8  encoded byte: count byte first, then value byte.
- in_last  input  1  marks the final value byte of a frame; sampled only with the value byte.
- in_ready  output  1  expander accepts in_data this cycle.
- fifo_full  input  1  downstream FIFO full flag.
- wr  output  1  write request to the FIFO.
- data_out  output  8  byte to write, valid while wr=1.
- busy  output  1  high while a run is being emitted or a token is half-received.
- done  output  1  one-cycle pulse when the last byte of a frame has been accepted by the FIFO.
- out_count  output  STAT_W  total bytes accepted by the FIFO since reset; wraps modulo 2^STAT_W.

Behaviour:
- Reset (asynchronous, rst=1), effective immediately:
  - State goes to S_COUNT.
  - Run counter, value register, last flag, out_count and done all clear to 0.
  - wr=0, busy=0, in_ready is 1 after reset is released.
- Reset mid-run abandons the partial run and any half-received token. Nothing is replayed.
- Byte transfer: a byte is accepted when in_valid & in_ready at the wclk edge.
- FIFO write: a byte is written when wr & ~fifo_full at the wclk edge, matching the FIFO's internal write enable.
- Run counter: 9 bits wide, holds 0..256.
- State S_COUNT:
  - in_ready=1, wr=0.
  - On accept, load the counter from in_data. With ZERO_IS_MAX=1, in_data=0 loads 256.
  - Next state S_VALUE.
  - busy=0 in S_COUNT.
- State S_VALUE:
  - in_ready=1, wr=0, busy=1.
  - On accept, capture the value register from in_data and the last flag from in_last.
  - If counter=0, go to S_COUNT. If the last flag was set, pulse done on the following cycle.
  - Otherwise go to S_EMIT.
- State S_EMIT:
  - in_ready=0, wr=1, data_out=value register, busy=1.
  - wr is driven combinationally from state only. It never depends on fifo_full, so there is no combinational loop.
  - At each edge with fifo_full=0: counter decrements and out_count increments.
  - If the counter was 1 at that edge, go to S_COUNT. If the last flag is set, done=1 for exactly the next cycle and the last flag clears.
  - With fifo_full=1: hold state, counter and data_out stable, keep wr=1.
- Latency and throughput:
  - First output byte appears the cycle after the value byte is accepted.
  - A run of N bytes occupies N cycles when the FIFO is never full.
  - Each token costs 2 ingest cycles with no overlap: in_ready=0 during S_EMIT.
- in_last on a count byte is ignored.
- in_valid=0 in S_COUNT or S_VALUE holds state indefinitely.
- data_out outside S_EMIT holds the last value register contents and is a don't-care.
- out_count wraps from 2^STAT_W-1 to 0 silently.
- done is never asserted together with a reset. A done due in the cycle of a reset is lost.

Decomposition:
- Shared package rle_pkg:
  - State encoding S_COUNT=2'd0, S_VALUE=2'd1, S_EMIT=2'd2, with 2'd3 recovering to S_COUNT.
  - WORD_W=8.
  - RUN_W=9.
- No sub-module. The FSM, run counter and statistics counter stay in one flat module.

Test Plan:
- Token (3, 8'hA5) with in_last=1, fifo_full=0:
  - wr high for exactly 3 cycles, data_out=A5 each cycle.
  - out_count=3, one done pulse the cycle after the third write, in_ready low during emit.
- Token (4, 8'h3C) with fifo_full=1 on emit cycles 2-3:
  - wr stays high and data_out stays 3C throughout.
  - Exactly 4 FIFO writes, 6 cycles total in S_EMIT.
- Tokens (0, 8'h11) then (2, 8'h22), ZERO_IS_MAX=0:
  - No write of 11; two writes of 22; out_count=2.
- Token (0, 8'h77), ZERO_IS_MAX=1:
  - 256 consecutive writes of 77, out_count=256.
- rst asserted in the 2nd emit cycle of a run of 5 bytes:
  - wr drops immediately; out_count=0, state S_COUNT, done not pulsed.
  - A following token (1, 8'h9E) emits a single 9E.
- STAT_W=4, fifteen single-byte tokens then (2, 8'h01):
  - out_count steps 15→0→1, i.e. wraps.

Source files
------------

// File: rtl/rle_pkg.sv
// rle_pkg: shared state encoding, widths and run-length decode helper for the RLE path.
package rle_pkg;

    localparam int WORD_W = 8;
    localparam int RUN_W  = 9;

    typedef enum logic [1:0] {
        S_COUNT = 2'd0,
        S_VALUE = 2'd1,
        S_EMIT  = 2'd2,
        S_BAD   = 2'd3
    } state_t;

    // A zero count byte is either an empty run or a full 256-byte run.
    function automatic logic [RUN_W-1:0] run_len(input logic [WORD_W-1:0] b, input bit zero_is_max);
        return (zero_is_max && b == '0) ? RUN_W'(256) : {1'b0, b};
    endfunction

endpackage

// File: rtl/rle_run_expander.sv
// rle_run_expander: expands (count, value) token pairs into repeated bytes pushed into a byte FIFO.
import rle_pkg::*;

module rle_run_expander #(
    parameter bit ZERO_IS_MAX = 1'b0,
    parameter int STAT_W      = 16
) (
    input  logic              wclk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              fifo_full,
    output logic              wr,
    output logic [WORD_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic [STAT_W-1:0] out_count
);

    state_t            state, state_n;
    logic [RUN_W-1:0]  cnt, cnt_n;
    logic [WORD_W-1:0] val, val_n;
    logic              last, last_n, done_n;
    logic              put;

    assign data_out = val;
    assign put      = (state == S_EMIT) && !fifo_full;

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            state     <= S_COUNT;
            cnt       <= '0;
            val       <= '0;
            last      <= 1'b0;
            done      <= 1'b0;
            out_count <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            val       <= val_n;
            last      <= last_n;
            done      <= done_n;
            out_count <= out_count + STAT_W'(put);
        end
    end

    // wr depends on state only so the FIFO full flag never loops back combinationally.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        val_n    = val;
        last_n   = last;
        done_n   = 1'b0;
        in_ready = 1'b0;
        wr       = 1'b0;
        busy     = 1'b0;
        case (state)
            S_COUNT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_n   = run_len(in_data, ZERO_IS_MAX);
                    state_n = S_VALUE;
                end
            end
            S_VALUE: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    val_n = in_data;
                    if (cnt == '0) begin
                        state_n = S_COUNT;
                        done_n  = in_last;
                        last_n  = 1'b0;
                    end else begin
                        last_n  = in_last;
                        state_n = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                wr   = 1'b1;
                busy = 1'b1;
                if (!fifo_full) begin
                    cnt_n = cnt - 1'b1;
                    if (cnt == RUN_W'(1)) begin
                        state_n = S_COUNT;
                        done_n  = last;
                        last_n  = 1'b0;
                    end
                end
            end
            default: state_n = S_COUNT;
        endcase
    end

endmodule
